dedup_pipeline: RTL and testbench
=================================

# dedup_pipeline

Multi-stage, fully pipelined lane deduplicator for N-wide tagged beats. It marks every kept lane whose value equals a lower-indexed kept lane in the same beat. Optionally, it also marks kept lanes that match a surviving lane of the previous beat in the same packet. Work is split across NUM_STAGES register stages, with real valid/ready backpressure. It sits between the dictionary input packer and the dictionary lookup stage, and replaces the chain of hand-instantiated single-range dedup stages.

## Interface
- DATA_W, 32, bits per lane
- NUM_ELEMENTS, 8, lanes per beat (N)
- NUM_STAGES, 2, within-beat compare stages (S); must divide N, 1 ≤ S ≤ N
- CROSS_BEAT, 1, 1 adds a cross-beat stage and history register; 0 omits them
- Derived: IDX_W = max(1, $clog2(N)); TAG_W = IDX_W + 2; lane tag = {duplicate, cross, origin[IDX_W-1:0]}; L = S + CROSS_BEAT
- Reset is rst_n, synchronous, active-low; the clock is clk.
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- in_data  in  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_keep  in  N  lane valid mask
- in_last  in  1  final beat of packet
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready at posedge
- out_data  out  N*DATA_W  input data, unmodified
- out_keep  out  N  in_keep with duplicate lanes cleared
- out_tag  out  N*TAG_W  per-lane tag, lane i at [i*TAG_W +: TAG_W]
- out_last  out  1  forwarded in_last
- out_valid / out_ready  out / in  1 / 1  output handshake

## Operation
- Candidate rule: lane j is a within-beat origin for lane i only if j < i, in_keep[j] = 1 (original mask) and data[j] == data[i]. The lowest such j is chosen. An origin is therefore never itself a duplicate.
- Stage s (0..S-1) resolves lanes [s*N/S, (s+1)*N/S) and registers data, the original keep, the working keep, tags, last and valid.
- Resolved duplicate lane i (only if in_keep[i] = 1):
  - tag = {1, 0, j}
  - out_keep[i] = 0
- Lanes with in_keep = 0 are never marked; their tag is 0.
- All non-duplicate tags are all-zero.
- Cross-beat stage (CROSS_BEAT = 1) compares each lane still kept after stage S-1 with the history lanes where hist_keep = 1. The lowest matching history index h gives:
  - tag = {1, 1, h}
  - keep bit cleared
- Within-beat marking takes precedence over cross-beat marking.
- History update, on each beat advancing into the cross-beat output register:
  - hist_data <= beat data
  - hist_keep <= beat's final out_keep
  - If the beat has last = 1, hist_keep <= 0 instead, so history never spans packets.
- A beat with all-zero keep passes with zero tags. It replaces the history with zero keep, or clears it if last.
- out_data is never altered.

## Timing
- Reset values: out_valid 0, out_last 0, out_keep 0, out_tag 0, all stage valids 0, hist_keep 0. out_data and internal data are don't-care. in_ready is 1 in the first cycle after reset is released.
- Reset mid-operation discards all in-flight beats and history; no output follows.
- Latency is L register stages. A beat accepted at edge t is presented on out_* after edge t+L-1.
- Stage advance: ready_k = !valid_k | ready_{k+1}, with ready_L = out_ready, and in_ready = ready_0.
  - Bubbles collapse.
  - Throughput is 1 beat/cycle while out_ready = 1.
- While a stage is stalled, its registers and therefore out_* stay stable. out_valid never drops without out_ready.
- No combinational path from in_* to out_*. A ready path from out_ready to in_ready is permitted.
- Beats exit in acceptance order; none are dropped or duplicated. With out_ready held low, at most L beats are buffered.
- The history update and the output register load occur on the same edge.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles while driving in_valid = 1 → out_valid = 0, out_keep = 0, out_tag = 0; in_ready = 1 after release; no output appears.
- Within-beat (DATA_W = 8, N = 8, S = 2, CROSS_BEAT = 1): lanes 0..7 = 5,3,5,7,3,5,9,1 with keep 0xFF → out_valid after edge t+2. Expected response:
  - out_keep = 0xCB
  - tag2 = {1,0,0}, tag4 = {1,0,1}, tag5 = {1,0,0}
  - all other tags 0; data unchanged
- Keep gating: lanes 0..2 = 5,6,5 with keep 0b11111110 → lane 2 is not a duplicate, tag2 = 0, out_keep = 0xFE.
- Cross-beat sequence:
  - Beat A, lanes 10..17 (10 + i per lane), last = 0 → no duplicates.
  - Beat B, lane 3 = 12, others 20..26, last = 1 → tag3 = {1,1,2}, out_keep = 0xF7.
  - Beat C, lane 0 = 12, last = 0 → no duplicate (history cleared by B's last).
- Backpressure: stream 6 distinct beats with out_ready = 0 for 5 cycles → in_ready = 0 after 3 beats are accepted. Outputs stay stable, all 6 beats emerge in order once out_ready = 1, and sustained throughput is 1 beat/cycle.
- Reset mid-packet: send a beat with lane 0 = 42, last = 0, pulse rst_n, then send a beat with lane 0 = 42 → the first beat never appears; the second beat's tag0 = 0.

Source files
------------

// File: rtl/dedup_pipeline.sv
// dedup_pipeline: pipelined lane deduplicator for N-wide tagged beats.
//
// A kept lane is marked when its value equals a lower-indexed lane whose
// original keep bit is set in the same beat (within-beat), or, with
// CROSS_BEAT = 1, when it equals a surviving lane of the previous beat of
// the same packet (cross-beat). Marked lanes have their keep bit cleared and
// receive a tag {duplicate, cross, origin}. Within-beat marking wins.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_data/in_keep/in_last  input beat (lane i at [i*DATA_W +: DATA_W])
//   in_valid/in_ready        input handshake
//   out_data                 input data, unmodified
//   out_keep                 in_keep with duplicate lanes cleared
//   out_tag                  per-lane tag (lane i at [i*TAG_W +: TAG_W])
//   out_last                 forwarded in_last
//   out_valid/out_ready      output handshake
module dedup_pipeline #(
  parameter int DATA_W       = 32,
  parameter int NUM_ELEMENTS = 8,
  parameter int NUM_STAGES   = 2,
  parameter int CROSS_BEAT   = 1,
  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1,
  localparam int TAG_W = IDX_W + 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ELEMENTS*DATA_W-1:0] in_data,
  input  logic [NUM_ELEMENTS-1:0]        in_keep,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_ELEMENTS*DATA_W-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0]        out_keep,
  output logic [NUM_ELEMENTS*TAG_W-1:0]  out_tag,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned N   = NUM_ELEMENTS;
  localparam int unsigned S   = NUM_STAGES;
  localparam int unsigned L   = NUM_STAGES + ((CROSS_BEAT != 0) ? 1 : 0);
  localparam int unsigned LPS = N / S;

  typedef logic [N-1:0][DATA_W-1:0] lanes_t;
  typedef logic [N-1:0][TAG_W-1:0]  tags_t;

  // Stage registers
  lanes_t         st_data  [L];
  logic [N-1:0]   st_okeep [L];
  logic [N-1:0]   st_wkeep [L];
  tags_t          st_tag   [L];
  logic [L-1:0]   st_last;
  logic [L-1:0]   st_valid;

  // Per-stage inputs (stage 0 sees the module inputs)
  lanes_t         src_data  [L];
  logic [N-1:0]   src_okeep [L];
  logic [N-1:0]   src_wkeep [L];
  tags_t          src_tag   [L];
  logic [L-1:0]   src_last;
  logic [L-1:0]   src_valid;

  // Per-stage resolved keep/tag
  logic [N-1:0]   nx_wkeep [L];
  tags_t          nx_tag   [L];

  logic [L-1:0]   ready;

  lanes_t         hist_data;
  logic [N-1:0]   hist_keep;

  always_comb begin
    src_data[0]  = in_data;
    src_okeep[0] = in_keep;
    src_wkeep[0] = in_keep;
    src_tag[0]   = '0;
    src_last     = '0;
    src_valid    = '0;
    src_last[0]  = in_last;
    src_valid[0] = in_valid;
    for (int unsigned k = 1; k < L; k++) begin
      src_data[k]  = st_data[k-1];
      src_okeep[k] = st_okeep[k-1];
      src_wkeep[k] = st_wkeep[k-1];
      src_tag[k]   = st_tag[k-1];
      src_last[k]  = st_last[k-1];
      src_valid[k] = st_valid[k-1];
    end
  end

  // Stages 0..S-1 each resolve their own lane slice against the original
  // keep mask; stage S (if present) checks surviving lanes against history.
  always_comb begin
    logic found;
    found = 1'b0;
    for (int unsigned k = 0; k < L; k++) begin
      nx_wkeep[k] = src_wkeep[k];
      nx_tag[k]   = src_tag[k];
      if (k < S) begin
        for (int unsigned i = 0; i < N; i++) begin
          if ((i / LPS) == k && src_okeep[k][i]) begin
            found = 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
              if (!found && j < i && src_okeep[k][j] &&
                  src_data[k][j] == src_data[k][i]) begin
                found          = 1'b1;
                nx_tag[k][i]   = {2'b10, IDX_W'(j)};
                nx_wkeep[k][i] = 1'b0;
              end
            end
          end
        end
      end else begin
        for (int unsigned i = 0; i < N; i++) begin
          if (src_wkeep[k][i]) begin
            found = 1'b0;
            for (int unsigned h = 0; h < N; h++) begin
              if (!found && hist_keep[h] &&
                  hist_data[h] == src_data[k][i]) begin
                found          = 1'b1;
                nx_tag[k][i]   = {2'b11, IDX_W'(h)};
                nx_wkeep[k][i] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // ready_k = !valid_k | ready_{k+1}, unrolled so no signal feeds itself.
  always_comb begin
    ready = '0;
    for (int unsigned k = 0; k < L; k++) begin
      ready[k] = out_ready;
      for (int unsigned m = 0; m < L; m++) begin
        if (m >= k && !st_valid[m]) ready[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < L; k++) begin
      if (!rst_n) begin
        st_valid[k] <= 1'b0;
        st_last[k]  <= 1'b0;
        st_okeep[k] <= '0;
        st_wkeep[k] <= '0;
        st_tag[k]   <= '0;
      end else if (ready[k]) begin
        st_valid[k] <= src_valid[k];
        if (src_valid[k]) begin
          st_data[k]  <= src_data[k];
          st_okeep[k] <= src_okeep[k];
          st_wkeep[k] <= nx_wkeep[k];
          st_tag[k]   <= nx_tag[k];
          st_last[k]  <= src_last[k];
        end
      end
    end
  end

  generate
    if (CROSS_BEAT != 0) begin : g_hist
      // History follows the beat entering the output register; a packet's
      // last beat leaves it empty so matches never span packets.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_keep <= '0;
        end else if (ready[L-1] && src_valid[L-1]) begin
          hist_data <= src_data[L-1];
          hist_keep <= src_last[L-1] ? '0 : nx_wkeep[L-1];
        end
      end
    end else begin : g_no_hist
      assign hist_data = '0;
      assign hist_keep = '0;
    end
  endgenerate

  assign in_ready  = ready[0];
  assign out_data  = st_data[L-1];
  assign out_keep  = st_wkeep[L-1];
  assign out_tag   = st_tag[L-1];
  assign out_last  = st_last[L-1];
  assign out_valid = st_valid[L-1];

endmodule

// File: tb/tb_dedup_pipeline.sv
// Directed bench for dedup_pipeline with DATA_W = 8, N = 8, S = 2,
// CROSS_BEAT = 1 (latency 3).
module tb_dedup_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [39:0] out_tag;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dedup_pipeline #(
    .DATA_W(8),
    .NUM_ELEMENTS(8),
    .NUM_STAGES(2),
    .CROSS_BEAT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_keep(in_keep),
    .in_last(in_last),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_tag(out_tag),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  ekeep;
    logic [39:0] etag;
  } vec_t;

  function automatic logic [63:0] pk(input logic [7:0] a0, a1, a2, a3,
                                     a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [39:0] tg(input int lane, input logic [4:0] t);
    logic [39:0] v;
    v = 40'(t);
    return v << (lane * 5);
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Offer one beat, then wait (bounded) for it at the output and compare.
  task automatic send(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    in_data  = v.data;
    in_keep  = v.keep;
    in_last  = v.last;
    in_valid = 1'b1;
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    check({name, " latency"}, 64'(lat), 64'd3);
    check({name, " keep"}, 64'(out_keep), 64'(v.ekeep));
    check({name, " tag"}, 64'(out_tag), 64'(v.etag));
    check({name, " data"}, out_data, v.data);
    check({name, " last"}, 64'(out_last), 64'(v.last));
  endtask

  vec_t tv [14];

  initial begin
    int   c;
    int   tx;
    int   rx;
    int   tx_at_stall;
    int   first_rx;
    int   last_rx;
    logic seen;

    tv[0]  = '{pk(5,3,5,7,3,5,9,1), 8'hFF, 1'b1, 8'hCB,
               tg(2,5'b10000) | tg(4,5'b10001) | tg(5,5'b10000)};
    tv[1]  = '{pk(5,6,5,1,2,3,4,7), 8'hFE, 1'b1, 8'hFE, 40'd0};
    tv[2]  = '{pk(10,11,12,13,14,15,16,17), 8'hFF, 1'b0, 8'hFF, 40'd0};
    tv[3]  = '{pk(20,21,22,12,23,24,25,26), 8'hFF, 1'b1, 8'hF7,
               tg(3,5'b11010)};
    tv[4]  = '{pk(12,30,31,32,33,34,35,36), 8'hFF, 1'b0, 8'hFF, 40'd0};
    tv[5]  = '{pk(40,30,41,12,42,43,44,45), 8'hFF, 1'b1, 8'hF5,
               tg(1,5'b11001) | tg(3,5'b11000)};
    tv[6]  = '{pk(1,2,3,4,5,6,7,8), 8'hFF, 1'b0, 8'hFF, 40'd0};
    tv[7]  = '{pk(2,2,50,51,52,53,54,55), 8'hFF, 1'b1, 8'hFC,
               tg(0,5'b11001) | tg(1,5'b10000)};
    tv[8]  = '{pk(60,61,62,63,64,65,66,67), 8'hFF, 1'b0, 8'hFF, 40'd0};
    tv[9]  = '{pk(60,61,62,63,64,65,66,67), 8'h00, 1'b0, 8'h00, 40'd0};
    tv[10] = '{pk(60,61,62,63,64,65,66,67), 8'hFF, 1'b1, 8'hFF, 40'd0};
    tv[11] = '{pk(9,9,9,9,9,9,9,9), 8'h05, 1'b1, 8'h01, tg(2,5'b10000)};
    tv[12] = '{pk(70,71,72,73,74,75,76,77), 8'h7F, 1'b0, 8'h7F, 40'd0};
    tv[13] = '{pk(77,70,80,81,82,83,84,85), 8'hFF, 1'b1, 8'hFD,
               tg(1,5'b11000)};

    // Reset held with input offered and output stalled
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = pk(1,1,1,1,1,1,1,1);
    in_keep   = 8'hFF;
    in_last   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_keep", 64'(out_keep), 64'd0);
      check("reset out_tag", 64'(out_tag), 64'd0);
      check("reset out_last", 64'(out_last), 64'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("in_ready after reset", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no output after reset", 64'(seen), 64'd0);
    out_ready = 1'b1;

    for (int unsigned i = 0; i < 14; i++) send(tv[i], $sformatf("vec%0d", i));

    // Backpressure: 6 distinct beats, output stalled for the first 5 cycles
    tx = 0; rx = 0; tx_at_stall = -1; first_rx = -1; last_rx = -1;
    for (c = 0; c < 60 && rx < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      #1;
      if (c == 4) tx_at_stall = tx;
      if (out_valid) begin
        check($sformatf("bp beat%0d data", rx), out_data,
              pk(8'(100+rx*8), 8'(101+rx*8), 8'(102+rx*8), 8'(103+rx*8),
                 8'(104+rx*8), 8'(105+rx*8), 8'(106+rx*8), 8'(107+rx*8)));
        check($sformatf("bp beat%0d keep", rx), 64'(out_keep), 64'hFF);
        if (out_ready) begin
          if (first_rx < 0) first_rx = c;
          last_rx = c;
          rx++;
        end
      end
      if (tx < 6) begin
        in_data  = pk(8'(100+tx*8), 8'(101+tx*8), 8'(102+tx*8), 8'(103+tx*8),
                      8'(104+tx*8), 8'(105+tx*8), 8'(106+tx*8), 8'(107+tx*8));
        in_keep  = 8'hFF;
        in_last  = 1'b1;
        in_valid = 1'b1;
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp accepted while stalled", 64'(tx_at_stall), 64'd3);
    check("bp beats out", 64'(rx), 64'd6);
    check("bp first out cycle", 64'(first_rx), 64'd5);
    check("bp throughput span", 64'(last_rx - first_rx), 64'd5);

    // Reset mid-packet: history and in-flight beat must both be discarded
    send('{pk(42,90,91,92,93,94,95,96), 8'hFF, 1'b0, 8'hFF, 40'd0}, "pre");
    @(negedge clk);
    in_data  = pk(77,97,98,99,10,11,12,13);
    in_keep  = 8'hFF;
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("in-flight beat dropped", 64'(seen), 64'd0);
    send('{pk(42,100,101,102,103,104,105,106), 8'hFF, 1'b1, 8'hFF, 40'd0},
         "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
